// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MEM stage: held dcache request, load hold, branch/jump redirect, sticky halt.
// Optional MEM_WATCHDOG_EN adds a WAIT-cycle watchdog driving mem_err.
module memory_stage #(
  parameter int unsigned WATCHDOG_LIMIT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        in_dREN,
  input  logic        in_dWEN,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_store,
  input  logic        in_Branch,
  input  logic        in_bne,
  input  logic        in_zero,
  input  logic [31:0] in_baddr,
  input  logic        in_Jump,
  input  logic [31:0] in_jaddr,
  input  logic        in_halt,
  input  logic        advance,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        pc_redirect,
  output logic [31:0] redirect_addr,
  output logic        halted,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, next_state;
  logic        op, is_wr, is_rd, req, hit_rd, stall, taken;
  logic [31:0] load_q;
  logic        halted_q, err_q;

  // A store wins when both controls are set.
  assign op     = in_dWEN | in_dREN;
  assign is_wr  = in_dWEN;
  assign is_rd  = in_dREN & ~in_dWEN;
  assign req    = ~halted_q & (((state == IDLE) & op) | (state == WAIT));
  assign hit_rd = req & is_rd & dhit;
  assign stall  = req & ~dhit;
  assign taken  = (in_Branch & in_zero) | (in_bne & ~in_zero) | in_Jump;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      load_q   <= 32'd0;
      halted_q <= 1'b0;
    end else begin
      state <= next_state;
      if (hit_rd)
        load_q <= dmemload;
      if (in_halt & advance)
        halted_q <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req) next_state = dhit ? (advance ? IDLE : DONE) : WAIT;
      WAIT: if (dhit) next_state = advance ? IDLE : DONE;
      DONE: if (advance) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

`ifdef MEM_WATCHDOG_EN
  logic [7:0] wd_cnt, wd_next;

  assign wd_next = (wd_cnt == 8'hFF) ? wd_cnt : wd_cnt + 8'd1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wd_cnt <= 8'd0;
      err_q  <= 1'b0;
    end else if (state == WAIT) begin
      wd_cnt <= wd_next;
      if ({24'd0, wd_next} >= WATCHDOG_LIMIT)
        err_q <= 1'b1;
    end else begin
      wd_cnt <= 8'd0;
    end
  end
`else
  assign err_q = 1'b0;
`endif

  // Every output is forced low while reset is held, including the request.
  assign dmemREN       = nRST & req & is_rd;
  assign dmemWEN       = nRST & req & is_wr;
  assign dmemaddr      = nRST ? in_addr : 32'd0;
  assign dmemstore     = nRST ? in_store : 32'd0;
  assign mem_stall     = nRST & stall;
  assign load_data     = !nRST ? 32'd0 : (hit_rd ? dmemload : load_q);
  assign pc_redirect   = nRST & taken & advance & ~stall;
  assign redirect_addr = !nRST ? 32'd0 : (in_Jump ? in_jaddr : in_baddr);
  assign halted        = halted_q;
  assign mem_err       = err_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized self-checking bench for memory_stage against a transaction-level model.
module tb_memory_stage;

`ifdef MEM_WATCHDOG_EN
  localparam int unsigned WL = 4;
`else
  localparam int unsigned WL = 255;
`endif

  logic        CLK = 1'b0, nRST = 1'b0;
  logic        in_dREN = 1'b0, in_dWEN = 1'b0, in_Branch = 1'b0, in_bne = 1'b0, in_zero = 1'b0;
  logic        in_Jump = 1'b0, in_halt = 1'b0, advance = 1'b0, dhit = 1'b0;
  logic [31:0] in_addr = 32'd0, in_store = 32'd0, in_baddr = 32'd0, in_jaddr = 32'd0, dmemload = 32'd0;
  logic        dmemREN, dmemWEN, mem_stall, pc_redirect, halted, mem_err;
  logic [31:0] dmemaddr, dmemstore, load_data, redirect_addr;

  int errors = 0, checks = 0;
  logic [31:0] last_load = 32'd0;

  memory_stage #(.WATCHDOG_LIMIT(WL)) dut (
    .CLK(CLK), .nRST(nRST), .in_dREN(in_dREN), .in_dWEN(in_dWEN), .in_addr(in_addr),
    .in_store(in_store), .in_Branch(in_Branch), .in_bne(in_bne), .in_zero(in_zero),
    .in_baddr(in_baddr), .in_Jump(in_Jump), .in_jaddr(in_jaddr), .in_halt(in_halt),
    .advance(advance), .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
    .load_data(load_data), .pc_redirect(pc_redirect), .redirect_addr(redirect_addr),
    .halted(halted), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One memory instruction: n miss cycles, hit, then d cycles of downstream stall.
  task automatic mem_op(input bit wr, input bit both, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] rdata,
                        input int n, input int d, input bit adv_miss);
    in_dWEN = wr;
    in_dREN = !wr || both;
    in_addr = addr;
    in_store = data;
    for (int k = 0; k <= n; k++) begin
      dhit = (k == n);
      dmemload = (k == n) ? rdata : $urandom;
      advance = (k < n) ? adv_miss : (d == 0);
      #2;
      chk("ren", dmemREN, !wr);
      chk("wen", dmemWEN, wr);
      chk("addr", dmemaddr, addr);
      chk("store", dmemstore, data);
      chk("stall", mem_stall, k < n);
      chk("redir_mem", pc_redirect, 0);
      chk("err", mem_err, 0);
      if (!wr && k == n) last_load = rdata;
      chk("ld_hit", load_data, (!wr && k == n) ? rdata : last_load);
      tick();
    end
    for (int j = 0; j < d; j++) begin
      dhit = $urandom_range(1);
      dmemload = $urandom;
      advance = (j == d - 1);
      #2;
      chk("ren_done", dmemREN, 0);
      chk("wen_done", dmemWEN, 0);
      chk("stall_done", mem_stall, 0);
      chk("ld_hold", load_data, last_load);
      tick();
    end
    in_dREN = 0; in_dWEN = 0; dhit = 0; advance = 0;
  endtask

  task automatic ctl(input bit br, input bit bn, input bit z, input bit jp,
                     input logic [31:0] ba, input logic [31:0] ja);
    bit tk;
    tk = jp || (br && z) || (bn && !z);
    in_Branch = br; in_bne = bn; in_zero = z; in_Jump = jp; in_baddr = ba; in_jaddr = ja;
    advance = 0;
    #2;
    chk("redir_hold", pc_redirect, 0);
    chk("raddr", redirect_addr, jp ? ja : ba);
    tick();
    advance = 1;
    #2;
    chk("redir_fire", pc_redirect, tk);
    tick();
    in_Branch = 0; in_bne = 0; in_Jump = 0; advance = 0;
  endtask

  initial begin
    // Outputs forced low during reset even with a load presented.
    in_dREN = 1; in_addr = 32'h123; in_store = 32'h456;
    #3;
    chk("rst_ren", dmemREN, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_addr", dmemaddr, 0);
    chk("rst_ld", load_data, 0);
    chk("rst_halt", halted, 0);
    chk("rst_err", mem_err, 0);
    in_dREN = 0;
    tick();
    nRST = 1;
    tick();

    mem_op(0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0, 1);
    mem_op(1, 0, 32'h104, 32'h12345678, 32'h0, 0, 0, 0);
    mem_op(0, 0, 32'h108, 32'h0, 32'hCAFEF00D, 0, 2, 0);
    ctl(1, 0, 1, 0, 32'h40, 32'h0);
    ctl(0, 1, 1, 0, 32'h80, 32'h0);
    ctl(0, 0, 0, 1, 32'h44, 32'h200);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0)
        ctl($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom, $urandom);
      else
        mem_op($urandom_range(1), $urandom_range(1), $urandom, $urandom, $urandom,
               $urandom_range(3), $urandom_range(2), 0);
    end

    // Reset in the middle of a miss drops the request immediately.
    in_dREN = 1; in_addr = 32'h300; dhit = 0; advance = 0;
    tick(); tick();
    #2;
    chk("wait_ren", dmemREN, 1);
    nRST = 0;
    #1;
    chk("midrst_ren", dmemREN, 0);
    chk("midrst_stall", mem_stall, 0);
    in_dREN = 0;
    tick();
    nRST = 1;
    last_load = 0;
    #2;
    chk("post_rst_ld", load_data, 0);
    tick();
    mem_op(0, 0, 32'h304, 32'h0, 32'h0BADC0DE, 0, 0, 0);

`ifdef MEM_WATCHDOG_EN
    in_dREN = 1; in_addr = 32'h400; dhit = 0; advance = 0;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      #2;
      chk("wd_err", mem_err, k == 4);
    end
    chk("wd_req", dmemREN, 1);
    nRST = 0;
    in_dREN = 0;
    #2;
    chk("wd_clr", mem_err, 0);
    tick();
    nRST = 1;
    last_load = 0;
    tick();
    mem_op(0, 0, 32'h404, 32'h0, 32'h11112222, 0, 0, 0);
`endif

    // Halt only latches with advance, then blocks all requests.
    in_halt = 1; advance = 0;
    tick();
    #2;
    chk("halt_noadv", halted, 0);
    advance = 1;
    tick();
    in_halt = 0; advance = 0;
    #2;
    chk("halt_set", halted, 1);
    in_dREN = 1; in_addr = 32'h500;
    for (int k = 0; k < 3; k++) begin
      dhit = (k == 2);
      dmemload = $urandom;
      #2;
      chk("halt_ren", dmemREN, 0);
      chk("halt_stall", mem_stall, 0);
      chk("halt_ld", load_data, last_load);
      tick();
    end
    chk("halt_sticky", halted, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage sitting directly downstream of the EX/MEM latch and upstream of the MEM/WB latch. It converts the latched load/store controls into a held data-cache request and stalls the pipeline until `dhit`. It holds the returned load word until the MEM/WB latch accepts it, and resolves branches and jumps into a one-shot PC redirect. It also records a sticky halt.

## Interface
Parameters:
- `WATCHDOG_LIMIT`, default 255: cycles in WAIT before `mem_err` sets (only with `MEM_WATCHDOG_EN`).

Ports:
- `CLK`  in  1  clock, all state on rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `in_dREN`  in  1  latched load control.
- `in_dWEN`  in  1  latched store control.
- `in_addr`  in  32  latched ALU result (memory address).
- `in_store`  in  32  latched rdat2 (store data).
- `in_Branch`  in  1  beq.
- `in_bne`  in  1  bne.
- `in_zero`  in  1  ALU zero flag.
- `in_baddr`  in  32  branch target.
- `in_Jump`  in  1  j/jal/jr.
- `in_jaddr`  in  32  jump target.
- `in_halt`  in  1  halt opcode in stage.
- `advance`  in  1  MEM/WB latch enable; the instruction leaves this stage on a cycle with `advance`=1.
- `dhit`  in  1  cache completed current request.
- `dmemload`  in  32  cache read data, valid with `dhit`.
- `dmemREN`  out  1  cache read request.
- `dmemWEN`  out  1  cache write request.
- `dmemaddr`  out  32  request address.
- `dmemstore`  out  32  write data.
- `mem_stall`  out  1  freeze upstream latches and PC.
- `load_data`  out  32  load result to MEM/WB latch.
- `pc_redirect`  out  1  load PC with `redirect_addr`, flush IF/ID and ID/EX.
- `redirect_addr`  out  32  redirect target.
- `halted`  out  1  sticky halt.
- `mem_err`  out  1  sticky watchdog error.

## Operation
- Op present = `in_dWEN | in_dREN`. If both are set, the op is a write and the read is ignored.
- States: IDLE, WAIT, DONE. Reset sets the state to IDLE.
- IDLE:
  - If op present and not `halted`: drive the request this cycle.
  - If `dhit`=1 with `advance`=1: stay IDLE.
  - If `dhit`=1 with `advance`=0: go to DONE.
  - If `dhit`=0: go to WAIT.
- WAIT: hold the request. On `dhit`, go to IDLE if `advance`=1, else go to DONE.
- DONE: request is low and `mem_stall`=0. Go to IDLE on `advance`.
- `dmemaddr`=`in_addr` and `dmemstore`=`in_store` always (pass-through).
- `dmemREN`/`dmemWEN` high only in IDLE (with op present) or WAIT, and 0 when `halted`.
- `mem_stall` = request active & ~`dhit`.
- Load register captures `dmemload` on any `dhit` for a read.
- `load_data` = (`dhit` & read) ? `dmemload` : load register.
- Taken = (`in_Branch` & `in_zero`) | (`in_bne` & ~`in_zero`) | `in_Jump`.
- `pc_redirect` = taken & `advance` & ~`mem_stall`, so it fires once per instruction.
- `redirect_addr` = `in_Jump` ? `in_jaddr` : `in_baddr`.
- `halted` sets on `in_halt` & `advance` and clears only on reset.

## Timing
- Reset values:
  - State: IDLE.
  - `load_data` register: 0.
  - `halted`: 0.
  - `mem_err`: 0.
  - Watchdog count: 0.
  - All outputs 0 while `nRST` is low (request drops asynchronously).
- Latency:
  - A hit in the issue cycle gives 0 stall cycles.
  - A miss gives N stall cycles, where `dhit` arrives N cycles after issue.
- Reset mid-WAIT: request deasserts immediately and the op is not retried.
- `dhit` outside IDLE-with-op or WAIT is ignored.
- DONE guarantees no duplicate request while a downstream stall holds the instruction.
- `advance`=1 with a pending miss is a hazard-unit error. The stage does not leave WAIT without `dhit`.

## Configuration
- `MEM_WATCHDOG_EN` defined:
  - An 8-bit counter increments each WAIT cycle and clears on leaving WAIT.
  - When the count reaches `WATCHDOG_LIMIT`, `mem_err` sets, sticky until reset.
  - The request continues after `mem_err` sets.
- `MEM_WATCHDOG_EN` undefined: counter is absent and `mem_err` is tied 0.

## Test plan
- Load, `in_addr`=0x100, `dhit` 3 cycles after issue, `dmemload`=0xDEADBEEF, `advance` tied high -> `mem_stall`=1 for 3 cycles; `load_data`=0xDEADBEEF on the hit cycle; back to IDLE.
- Store hit in issue cycle, `in_store`=0x12345678 -> `dmemWEN` high 1 cycle, `dmemstore`=0x12345678, `mem_stall` never high.
- Load hit with `advance`=0 for 2 further cycles -> DONE; `dmemREN`=0; `load_data` holds the word; IDLE after `advance`.
- beq with `in_zero`=1, `in_baddr`=0x40 -> `pc_redirect` 1-cycle pulse, `redirect_addr`=0x40.
- bne with `in_zero`=1 -> no redirect.
- jump to 0x200 -> redirect to 0x200.
- halt advances, then a load is presented -> `halted`=1; `dmemREN` stays 0.
- With `MEM_WATCHDOG_EN`, `WATCHDOG_LIMIT`=4, `dhit` held low -> `mem_err`=1 after the 4th WAIT cycle; `nRST` pulse clears it and returns the state to IDLE.
